// File: rtl/alu_pkg.sv
// Shared ALU definitions: op-code encodings, the BIST vector record and its builder.
package alu_pkg;

    localparam int ALU_W = 32;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef struct packed {
        logic [ALU_W-1:0] a;
        logic [ALU_W-1:0] b;
        logic [3:0]       op;
        logic [ALU_W-1:0] exp_result;
        logic             exp_zero;
        logic             exp_ovf;
        logic             ovf_mask;
    } alu_vec_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } bist_state_t;

    function automatic alu_vec_t mk_vec(
        input logic [ALU_W-1:0] a,
        input logic [ALU_W-1:0] b,
        input logic [3:0]       op,
        input logic [ALU_W-1:0] res,
        input logic             zero,
        input logic             ovf,
        input logic             mask
    );
        alu_vec_t v;
        v.a          = a;
        v.b          = b;
        v.op         = op;
        v.exp_result = res;
        v.exp_zero   = zero;
        v.exp_ovf    = ovf;
        v.ovf_mask   = mask;
        return v;
    endfunction

endpackage

// File: rtl/alu_bist_rom.sv
// Fixed ALU self-test vector table; purely combinational index -> vector lookup.
module alu_bist_rom
    import alu_pkg::*;
#(
    parameter int IDX_W = 3
) (
    input  logic [IDX_W-1:0] i_idx,
    output alu_vec_t         o_vec
);

    localparam logic [ALU_W-1:0] W_MAXPOS = {1'b0, {(ALU_W-1){1'b1}}};
    localparam logic [ALU_W-1:0] W_MINNEG = {1'b1, {(ALU_W-1){1'b0}}};
    localparam logic [ALU_W-1:0] W_ONE    = ALU_W'(1);
    localparam logic [ALU_W-1:0] W_TWO    = ALU_W'(2);
    localparam logic [ALU_W-1:0] W_THREE  = ALU_W'(3);
    localparam logic [ALU_W-1:0] W_ZERO   = '0;

    // Overflow is only meaningful (mask=1) for ADD and SUB.
    always_comb begin
        o_vec = '0;
        case (i_idx)
            IDX_W'(0): o_vec = mk_vec(W_TWO,    W_ONE, ALU_AND, W_ZERO,   1'b1, 1'b0, 1'b0);
            IDX_W'(1): o_vec = mk_vec(W_TWO,    W_ONE, ALU_OR,  W_THREE,  1'b0, 1'b0, 1'b0);
            IDX_W'(2): o_vec = mk_vec(W_TWO,    W_ONE, ALU_ADD, W_THREE,  1'b0, 1'b0, 1'b1);
            IDX_W'(3): o_vec = mk_vec(W_TWO,    W_ONE, ALU_SUB, W_ONE,    1'b0, 1'b0, 1'b1);
            IDX_W'(4): o_vec = mk_vec(W_TWO,    W_ONE, ALU_SLT, W_ZERO,   1'b1, 1'b0, 1'b0);
            IDX_W'(5): o_vec = mk_vec(W_ONE,    W_TWO, ALU_SLT, W_ONE,    1'b0, 1'b0, 1'b0);
            IDX_W'(6): o_vec = mk_vec(W_TWO,    W_ONE, ALU_NOR, ~W_THREE, 1'b0, 1'b0, 1'b0);
            IDX_W'(7): o_vec = mk_vec(W_MAXPOS, W_ONE, ALU_ADD, W_MINNEG, 1'b0, 1'b1, 1'b1);
            default:   o_vec = '0;
        endcase
    end

endmodule

// File: rtl/alu_bist.sv
// ALU built-in self-test sequencer: drives the vector table, checks results, reports pass/fail.
// Optional macro ALU_BIST_STOP_ON_FAIL_EN ends the run at the first mismatching vector.
module alu_bist
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NUM_VEC = 8,
    localparam int IDX_W  = $clog2(NUM_VEC),
    localparam int CNT_W  = $clog2(NUM_VEC + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] fail_count,
    output logic [IDX_W-1:0] first_fail_idx,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic             alu_overflow
);

    bist_state_t      r_state;
    bist_state_t      w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_load_idx;
    logic             w_load;
    logic             w_last;
    logic             w_mismatch;
    logic             w_stop;
    alu_vec_t         w_rom_vec;

    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [3:0]       r_alu_control;
    logic [WIDTH-1:0] r_exp_result;
    logic             r_exp_zero;
    logic             r_exp_ovf;
    logic             r_ovf_mask;
    logic [CNT_W-1:0] r_fail_count;
    logic [IDX_W-1:0] r_first_fail_idx;
    logic             r_pass;

    alu_bist_rom #(
        .IDX_W (IDX_W)
    ) u_rom (
        .i_idx (w_load_idx),
        .o_vec (w_rom_vec)
    );

    assign w_last     = (r_idx == IDX_W'(NUM_VEC - 1));
    assign w_mismatch = (alu_result != r_exp_result)
                     || (alu_zero != r_exp_zero)
                     || (r_ovf_mask && (alu_overflow != r_exp_ovf));

`ifdef ALU_BIST_STOP_ON_FAIL_EN
    assign w_stop = w_mismatch;
`else
    assign w_stop = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The ROM is addressed by the index about to be loaded, so operands and
    // expectations are registered together and stay stable through SETTLE/CHECK.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_idx  = '0;
        busy        = (r_state != ST_IDLE);
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                w_state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                if (w_last || w_stop) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_load      = 1'b1;
                    w_load_idx  = r_idx + 1'b1;
                    w_state_nxt = ST_SETTLE;
                end
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx            <= '0;
            r_alu_a          <= '0;
            r_alu_b          <= '0;
            r_alu_control    <= '0;
            r_exp_result     <= '0;
            r_exp_zero       <= 1'b0;
            r_exp_ovf        <= 1'b0;
            r_ovf_mask       <= 1'b0;
            r_fail_count     <= '0;
            r_first_fail_idx <= '0;
            r_pass           <= 1'b0;
        end else begin
            if (w_load) begin
                r_idx         <= w_load_idx;
                r_alu_a       <= WIDTH'(w_rom_vec.a);
                r_alu_b       <= WIDTH'(w_rom_vec.b);
                r_alu_control <= w_rom_vec.op;
                r_exp_result  <= WIDTH'(w_rom_vec.exp_result);
                r_exp_zero    <= w_rom_vec.exp_zero;
                r_exp_ovf     <= w_rom_vec.exp_ovf;
                r_ovf_mask    <= w_rom_vec.ovf_mask;
            end
            if ((r_state == ST_IDLE) && start) begin
                r_fail_count     <= '0;
                r_first_fail_idx <= '0;
                r_pass           <= 1'b0;
            end
            if ((r_state == ST_CHECK) && w_mismatch) begin
                r_fail_count <= r_fail_count + 1'b1;
                if (r_fail_count == '0) begin
                    r_first_fail_idx <= r_idx;
                end
            end
            // Pass is resolved on the way into DONE so it is valid alongside done.
            if ((r_state == ST_CHECK) && (w_state_nxt == ST_DONE)) begin
                r_pass <= (r_fail_count == '0) && !w_mismatch;
            end
        end
    end

    assign alu_a          = r_alu_a;
    assign alu_b          = r_alu_b;
    assign alu_control    = r_alu_control;
    assign fail_count     = r_fail_count;
    assign first_fail_idx = r_first_fail_idx;
    assign pass           = r_pass;

endmodule

// File: doc/alu_bist.md
# alu_bist

Synthesizable built-in self-test sequencer for the MIPS ALU. It sits on the initiator side of the ALU operand/control interface. On `start` it drives a fixed vector table into the ALU's `A`, `B` and `control` inputs. It then checks the returned `result`, `zero` and `overflow` against expected values and reports pass/fail and the first failing vector. It shares the ALU operand bus with the datapath through an upstream mux, which selects `alu_bist` whenever `busy` is high.

## Interface
- `WIDTH`, 32: operand and result width.
- `NUM_VEC`, 8: number of entries in the vector table.
- `clk` in, 1 bit: single clock.
- `reset` in, 1 bit: synchronous, active-high reset.
- `start` in, 1 bit: begins a run; sampled only in IDLE.
- `busy` out, 1 bit: high from the start edge until DONE is left.
- `done` out, 1 bit: one-cycle pulse when the run ends.
- `pass` out, 1 bit: high when the last run had zero mismatches.
- `fail_count` out, $clog2(NUM_VEC+1) bits: number of mismatching vectors.
- `first_fail_idx` out, $clog2(NUM_VEC) bits: index of the first mismatch; valid when `fail_count` != 0.
- `alu_a` out, WIDTH bits: drives ALU operand A.
- `alu_b` out, WIDTH bits: drives ALU operand B.
- `alu_control` out, 4 bits: drives the ALU op code.
- `alu_result` in, WIDTH bits: ALU result.
- `alu_zero` in, 1 bit: ALU zero flag.
- `alu_overflow` in, 1 bit: ALU overflow flag.

## Operation
- **Op encodings:**
  - AND = 0000
  - OR = 0001
  - ADD = 0010
  - SUB = 0110
  - SLT = 0111
  - NOR = 1100
- **Vector table** (A, B, op → result / zero / overflow):
  - 0: 2, 1, AND → 0 / 1 / –
  - 1: 2, 1, OR → 3 / 0 / –
  - 2: 2, 1, ADD → 3 / 0 / 0
  - 3: 2, 1, SUB → 1 / 0 / 0
  - 4: 2, 1, SLT → 0 / 1 / –
  - 5: 1, 2, SLT → 1 / 0 / –
  - 6: 2, 1, NOR → 0xFFFFFFFC / 0 / –
  - 7: 0x7FFFFFFF, 1, ADD → 0x80000000 / 0 / 1
- **Overflow check:** `overflow` is compared only for ADD and SUB. It is a don't-care ("–") otherwise, enforced by a per-vector mask bit.
- **Mismatch rule:** a vector mismatches if `result` differs, or `zero` differs, or the masked `overflow` differs.
- **States:**
  - IDLE: `start`=1 → load vector 0 onto `alu_*`, idx=0, clear `fail_count`/`first_fail_idx`/`pass` → SETTLE.
  - SETTLE: unconditional → CHECK. Gives the ALU combinational path a full cycle.
  - CHECK: compare. On mismatch, increment `fail_count`; if it was 0, capture idx into `first_fail_idx`. If idx == NUM_VEC-1 → DONE. Otherwise idx++, load the next vector → SETTLE.
  - DONE: `done`=1, `pass` = (`fail_count`==0) registered → IDLE.
- **`start` outside IDLE:** ignored, including during the DONE cycle. Holding `start` high starts a new run on the cycle after DONE.
- **Output hold:** `alu_*` outputs hold their last vector in IDLE and DONE. `pass`/`fail_count`/`first_fail_idx` hold until the next accepted `start`.
- **`fail_count` saturation:** not needed, since its width covers NUM_VEC.

## Timing
- **Reset values:**
  - state = IDLE, idx = 0
  - `busy`, `done`, `pass` = 0
  - `fail_count` = 0, `first_fail_idx` = 0
  - `alu_a`, `alu_b`, `alu_control` = 0
- **Reset mid-run:** aborts immediately. All outputs take their reset values the following cycle, with no `done` pulse. The next `start` runs from vector 0.
- **Per-vector cost:** 2 cycles.
- **Latency:** start sampled at edge E0 → `done` high in the cycle after edge E(2·NUM_VEC), i.e. edge 16 for the default table.
- **`busy`:** high from E0 through the DONE cycle.
- **Result outputs:** `pass` is valid in the same cycle as `done`.

## Configuration
- Macro: `ALU_BIST_STOP_ON_FAIL_EN`.
- **Defined:** the first mismatch in CHECK goes directly to DONE. The result is `fail_count`=1 and `first_fail_idx`=idx, and the remaining vectors are not driven.
- **Undefined:** all NUM_VEC vectors are always run and every mismatch is counted.

## Structure
- **Shared package `alu_pkg`:**
  - ALU op-code localparams (AND/OR/ADD/SUB/SLT/NOR), shared with the ALU and ALU control.
  - Vector struct typedef: a, b, op, exp_result, exp_zero, exp_ovf, ovf_mask.
- **Sub-module `alu_bist_rom`:** combinational, index → vector struct, holding the table above. The FSM and comparator stay in `alu_bist`.

## Test plan
1. **Clean run:** reset, then pulse `start` with the real ALU attached → `alu_control` sequence is 0000, 0001, 0010, 0110, 0111, 0111, 1100, 0010. `done` arrives 16 cycles after the start edge with `pass`=1 and `fail_count`=0.
2. **Stuck result bit:** force `alu_result[0]`=0 → vectors 1, 2, 3 and 5 fail, giving `fail_count`=4, `first_fail_idx`=1, `pass`=0. With `ALU_BIST_STOP_ON_FAIL_EN` defined: `done` at cycle 4, `fail_count`=1, `first_fail_idx`=1.
3. **Stuck overflow:** force `alu_overflow`=1 → only vectors 2 and 3 fail, giving `fail_count`=2 and `first_fail_idx`=2. Masked vectors and vector 7 pass.
4. **Start while busy:** hold `start` high for 5 cycles mid-run → the run is unaffected and `done` still arrives at cycle 16. With `start` held, a new run begins the cycle after DONE and `fail_count` is cleared.
5. **Reset mid-run:** assert `reset` at cycle 5 → the next cycle shows `busy`=0, `done`=0, `fail_count`=0 and `alu_a`/`alu_b`/`alu_control`=0, with no `done` pulse. A new `start` completes in 16 cycles with `pass`=1.
6. **Zero flag fault:** force `alu_zero`=0 → vectors 0 and 4 fail, giving `fail_count`=2 and `first_fail_idx`=0.
